// File: rtl/psdsqrt_seq.sv
// Operand FIFO and start/run/stop sequencer for the external iterative square-root core.
// States: IDLE pop head | START core load | RUN NBITS/2 iterations | STOP core latch | CAPT grab root | OUT hold result
module psdsqrt_seq #(
    parameter int NBITS      = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid_i,
    output logic                          in_ready_o,
    input  logic [NBITS-1:0]              in_data_i,
    output logic                          out_valid_o,
    input  logic                          out_ready_i,
    output logic [NBITS/2-1:0]            out_sqrt_o,
    output logic [NBITS-1:0]              out_xin_o,
    output logic                          sq_start_o,
    output logic                          sq_stop_o,
    output logic [NBITS-1:0]              sq_xin_o,
    input  logic [NBITS/2-1:0]            sq_result_i,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = NBITS / 2;
    localparam int IW = $clog2(RW);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_STOP,
        S_CAPT,
        S_OUT
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     iter_q, iter_d;
    logic [NBITS-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;
    logic [NBITS-1:0]  sq_xin_q, out_xin_q;
    logic [RW-1:0]     out_sqrt_q;
    logic              push, pop, capt;

    assign in_ready_o   = (count_q != CW'(FIFO_DEPTH));
    assign push         = in_valid_i & in_ready_o;
    assign busy_o       = (state_q != S_IDLE);
    assign fifo_count_o = count_q;
    assign sq_xin_o     = sq_xin_q;
    assign out_xin_o    = out_xin_q;
    assign out_sqrt_o   = out_sqrt_q;

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        pop         = 1'b0;
        capt        = 1'b0;
        sq_start_o  = 1'b0;
        sq_stop_o   = 1'b0;
        out_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (count_q != '0) begin
                    pop     = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                sq_start_o = 1'b1;
                iter_d     = IW'(RW - 1);
                state_d    = S_RUN;
            end
            S_RUN: begin
                if (iter_q == '0) begin
                    state_d = S_STOP;
                end else begin
                    iter_d = iter_q - 1'b1;
                end
            end
            S_STOP: begin
                sq_stop_o = 1'b1;
                state_d   = S_CAPT;
            end
            S_CAPT: begin
                capt    = 1'b1;
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid_o = 1'b1;
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= S_IDLE;
            iter_q     <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            sq_xin_q   <= '0;
            out_xin_q  <= '0;
            out_sqrt_q <= '0;
        end else begin
            state_q <= state_d;
            iter_q  <= iter_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                sq_xin_q  <= mem_q[rd_ptr_q];
                out_xin_q <= mem_q[rd_ptr_q];
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (capt) begin
                out_sqrt_q <= sq_result_i;
            end
        end
    end

    // Storage needs no reset: the pointers and count define which entries are live.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: tb/tb_psdsqrt_seq.sv
// Bench for psdsqrt_seq: directed steps plus random traffic, with a behavioural square-root core and scoreboard.
module tb_psdsqrt_seq;

    localparam int NBITS = 32;
    localparam int D     = 4;
    localparam int RW    = NBITS / 2;
    localparam int LAT   = RW + 5;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NBITS-1:0]  in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [RW-1:0]     out_sqrt;
    logic [NBITS-1:0]  out_xin;
    logic              sq_start, sq_stop;
    logic [NBITS-1:0]  sq_xin;
    logic [RW-1:0]     sq_result = '0;
    logic              busy;
    logic [$clog2(D):0] fifo_count;

    int checks = 0;
    int errors = 0;
    int results = 0;
    logic [NBITS-1:0] exp_q[$];
    logic [NBITS-1:0] core_x = '0;

    psdsqrt_seq #(.NBITS(NBITS), .FIFO_DEPTH(D)) dut (
        .clock        (clock),
        .reset        (reset),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_data_i    (in_data),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .out_sqrt_o   (out_sqrt),
        .out_xin_o    (out_xin),
        .sq_start_o   (sq_start),
        .sq_stop_o    (sq_stop),
        .sq_xin_o     (sq_xin),
        .sq_result_i  (sq_result),
        .busy_o       (busy),
        .fifo_count_o (fifo_count)
    );

    always #5 clock = ~clock;

    function automatic logic [RW-1:0] isqrt(input logic [NBITS-1:0] x);
        longint r = 0;
        longint c;
        for (int b = RW - 1; b >= 0; b--) begin
            c = r | (longint'(1) << b);
            if (c * c <= longint'(x)) r = c;
        end
        return RW'(r);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 500) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(busy === 1'b0 && fifo_count === '0 && out_valid === 1'b0) && n < 3000) begin
            tick();
            n++;
        end
        check("idle_reached", 64'(n < 3000), 64'd1);
    endtask

    // Square-root core model: loads on start, presents the root after stop.
    always @(posedge clock) begin
        if (sq_start) core_x <= sq_xin;
        if (sq_stop)  sq_result <= isqrt(core_x);
    end

    // Scoreboard: operands in acceptance order, compared against each delivered result.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            check("start_stop_exclusive", 64'(sq_start & sq_stop), 64'd0);
            if (in_valid && in_ready) exp_q.push_back(in_data);
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    check("sb_xin", out_xin, exp_q[0]);
                    check("sb_sqrt", out_sqrt, isqrt(exp_q[0]));
                    void'(exp_q.pop_front());
                end
                results++;
            end
        end
    end

    logic [NBITS-1:0] t1_x [6] = '{32'd0, 32'd1, 32'd15, 32'd16, 32'd144, 32'hFFFF_FFFF};
    logic [RW-1:0]    t1_r [6] = '{16'd0, 16'd1, 16'd3, 16'd4, 16'd12, 16'hFFFF};
    logic [NBITS-1:0] t3_x [6] = '{32'd4, 32'd9, 32'd25, 32'd100, 32'd65535, 32'd99};

    initial begin
        int n, r0, sent, guard;
        logic bad;
        logic [NBITS-1:0] d;
        int unsigned k;

        repeat (3) tick();
        check("rst_in_ready",  in_ready,   1);
        check("rst_out_valid", out_valid,  0);
        check("rst_sq_start",  sq_start,   0);
        check("rst_sq_stop",   sq_stop,    0);
        check("rst_sq_xin",    sq_xin,     0);
        check("rst_out_sqrt",  out_sqrt,   0);
        check("rst_out_xin",   out_xin,    0);
        check("rst_busy",      busy,       0);
        check("rst_count",     fifo_count, 0);
        reset = 1'b0;
        tick();

        // Single operations with the consumer always ready
        out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = t1_x[i];
            tick();
            in_valid = 1'b0;
            wait_out(n);
            check("t1_latency", 64'(n + 1), 64'(LAT));
            check("t1_sqrt", out_sqrt, t1_r[i]);
            check("t1_xin", out_xin, t1_x[i]);
            tick();
            check("t1_release", out_valid, 0);
        end

        // Backpressure holds the result stable
        r0 = results;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'd1000000;
        tick();
        in_valid = 1'b0;
        wait_out(n);
        check("t2_latency", 64'(n + 1), 64'(LAT));
        repeat (10) begin
            tick();
            check("t2_hold_valid", out_valid, 1);
            check("t2_hold_sqrt", out_sqrt, 16'd1000);
            check("t2_hold_xin", out_xin, 32'd1000000);
        end
        out_ready = 1'b1;
        tick();
        check("t2_release", out_valid, 0);
        check("t2_accepted", 64'(results - r0), 64'd1);

        // FIFO fill: one in flight, four queued, sixth stalls until a pop
        r0 = results;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = t3_x[i];
            if (i == 5) begin
                check("t3_full_ready", in_ready, 0);
                check("t3_full_count", fifo_count, D);
            end
            n = 0;
            while (in_ready !== 1'b1 && n < 100) begin
                tick();
                n++;
            end
            tick();
        end
        in_valid = 1'b0;
        wait_idle();
        check("t3_results", 64'(results - r0), 64'd6);

        // Push on the same edge the sequencer pops
        r0 = results;
        in_valid = 1'b1;
        in_data  = 32'd49;
        tick();
        check("t4_count_first", fifo_count, 1);
        in_data = 32'd50;
        tick();
        in_valid = 1'b0;
        check("t4_count_same", fifo_count, 1);
        check("t4_busy", busy, 1);
        wait_idle();
        check("t4_results", 64'(results - r0), 64'd2);

        // Reset while running with two operands queued
        r0 = results;
        in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_data = 32'd400 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        check("t5_pre_count", fifo_count, 2);
        check("t5_pre_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t5_count", fifo_count, 0);
        check("t5_busy", busy, 0);
        check("t5_sq_start", sq_start, 0);
        check("t5_sq_stop", sq_stop, 0);
        check("t5_out_valid", out_valid, 0);
        check("t5_in_ready", in_ready, 1);
        bad = 1'b0;
        repeat (30) begin
            tick();
            if (out_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        check("t5_quiet", bad, 0);
        check("t5_no_results", 64'(results - r0), 64'd0);
        in_valid = 1'b1;
        in_data  = 32'd81;
        tick();
        in_valid = 1'b0;
        wait_out(n);
        check("t5_new_latency", 64'(n + 1), 64'(LAT));
        check("t5_new_sqrt", out_sqrt, 16'd9);
        tick();

        // Random traffic with random consumer readiness
        r0 = results;
        sent = 0;
        guard = 0;
        while (sent < 1000 && guard < 60000) begin
            case ($urandom_range(0, 3))
                0: d = $urandom;
                1: d = 32'($urandom_range(0, 255));
                2: begin
                    k = $urandom_range(0, 65535);
                    d = 32'(k * k) - 32'($urandom_range(0, 1));
                end
                default: d = $urandom >> $urandom_range(0, 31);
            endcase
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = d;
            out_ready = $urandom_range(0, 1) == 1;
            if (in_valid && in_ready) sent++;
            tick();
            guard++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("t6_sent", 64'(sent), 64'd1000);
        wait_idle();
        check("t6_results", 64'(results - r0), 64'd1000);
        check("t6_sb_drained", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
